// File: rtl/ram_arbiter.sv
// Zero-fill sequencer plus independent round-robin write and read arbiters for a
// simple dual-port block RAM (registered read address, unregistered data out).
module ram_arbiter #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8,
    parameter int NREQ       = 4,
    parameter int ID_WIDTH   = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NREQ-1:0]            wreq,
    input  logic [NREQ*ADDR_WIDTH-1:0] waddr,
    input  logic [NREQ*DATA_WIDTH-1:0] wdata,
    output logic [NREQ-1:0]            wack,
    input  logic [NREQ-1:0]            rreq,
    input  logic [NREQ*ADDR_WIDTH-1:0] raddr,
    output logic [NREQ-1:0]            rack,
    output logic                       rvalid,
    output logic [ID_WIDTH-1:0]        rid,
    output logic [DATA_WIDTH-1:0]      rdata,
    output logic                       init_done,
    output logic                       ram_we,
    output logic [ADDR_WIDTH-1:0]      ram_waddr,
    output logic [DATA_WIDTH-1:0]      ram_din,
    output logic [ADDR_WIDTH-1:0]      ram_raddr,
    input  logic [DATA_WIDTH-1:0]      ram_dout
);

    typedef enum logic {INIT, RUN} state_t;

    state_t                  state, state_d;
    logic [ADDR_WIDTH-1:0]   cnt, cnt_d;
    logic                    init_done_d;
    logic [ID_WIDTH-1:0]     wptr, wptr_d, rptr, rptr_d;
    logic [NREQ-1:0]         wack_d, rack_d;
    logic                    ram_we_d;
    logic [ADDR_WIDTH-1:0]   ram_waddr_d, ram_raddr_d;
    logic [DATA_WIDTH-1:0]   ram_din_d;
    logic [ID_WIDTH-1:0]     rd_id0, rd_id0_d, rd_id1;
    logic                    rd_v1;

    logic [NREQ-1:0]         w_elig, r_elig;
    logic [ID_WIDTH:0]       w_pick, r_pick;
    logic                    w_found, r_found;
    logic [ID_WIDTH-1:0]     w_win, r_win;

    // Returns {found, index}: first eligible requester at or after ptr, wrapping.
    function automatic logic [ID_WIDTH:0] rr_pick(input logic [NREQ-1:0] elig,
                                                  input logic [ID_WIDTH-1:0] ptr);
        logic              found;
        logic [ID_WIDTH-1:0] win;
        int                idx;
        found = 1'b0;
        win   = '0;
        idx   = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx = int'(ptr) + k;
            if (idx >= NREQ) idx = idx - NREQ;
            if (!found && elig[idx]) begin
                found = 1'b1;
                win   = ID_WIDTH'(idx);
            end
        end
        return {found, win};
    endfunction

    // Requests are levels held until the matching ack; an ack is a one-cycle pulse,
    // and the acked requester is ignored for that cycle so a held level is not granted twice.
    assign w_elig = wreq & ~wack;
    assign r_elig = rreq & ~rack;

    assign w_pick  = rr_pick(w_elig, wptr);
    assign r_pick  = rr_pick(r_elig, rptr);
    assign w_found = w_pick[ID_WIDTH];
    assign w_win   = w_pick[ID_WIDTH-1:0];
    assign r_found = r_pick[ID_WIDTH];
    assign r_win   = r_pick[ID_WIDTH-1:0];

    always_comb begin
        state_d     = state;
        cnt_d       = cnt;
        init_done_d = init_done | (state == RUN);
        wptr_d      = wptr;
        rptr_d      = rptr;
        wack_d      = '0;
        rack_d      = '0;
        ram_we_d    = 1'b0;
        ram_waddr_d = ram_waddr;
        ram_din_d   = ram_din;
        ram_raddr_d = ram_raddr;
        rd_id0_d    = rd_id0;

        case (state)
            INIT: begin
                ram_we_d    = 1'b1;
                ram_waddr_d = cnt;
                ram_din_d   = '0;
                cnt_d       = cnt + 1'b1;
                if (cnt == '1) state_d = RUN;
            end
            RUN: begin
                // Arbitration starts one cycle after the last fill write.
                if (init_done) begin
                    if (w_found) begin
                        wack_d      = NREQ'(1) << w_win;
                        ram_we_d    = 1'b1;
                        ram_waddr_d = waddr[int'(w_win)*ADDR_WIDTH +: ADDR_WIDTH];
                        ram_din_d   = wdata[int'(w_win)*DATA_WIDTH +: DATA_WIDTH];
                        wptr_d      = (w_win == ID_WIDTH'(NREQ-1)) ? '0 : w_win + 1'b1;
                    end
                    if (r_found) begin
                        rack_d      = NREQ'(1) << r_win;
                        ram_raddr_d = raddr[int'(r_win)*ADDR_WIDTH +: ADDR_WIDTH];
                        rd_id0_d    = r_win;
                        rptr_d      = (r_win == ID_WIDTH'(NREQ-1)) ? '0 : r_win + 1'b1;
                    end
                end
            end
            default: state_d = INIT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= INIT;
            cnt       <= '0;
            init_done <= 1'b0;
            wptr      <= '0;
            rptr      <= '0;
            wack      <= '0;
            rack      <= '0;
            ram_we    <= 1'b0;
            ram_waddr <= '0;
            ram_din   <= '0;
            ram_raddr <= '0;
            rd_id0    <= '0;
        end else begin
            state     <= state_d;
            cnt       <= cnt_d;
            init_done <= init_done_d;
            wptr      <= wptr_d;
            rptr      <= rptr_d;
            wack      <= wack_d;
            rack      <= rack_d;
            ram_we    <= ram_we_d;
            ram_waddr <= ram_waddr_d;
            ram_din   <= ram_din_d;
            ram_raddr <= ram_raddr_d;
            rd_id0    <= rd_id0_d;
        end
    end

    // Read return: grant cycle -> RAM data cycle -> registered rdata.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_v1  <= 1'b0;
            rd_id1 <= '0;
            rvalid <= 1'b0;
            rid    <= '0;
            rdata  <= '0;
        end else begin
            rd_v1  <= |rack;
            rd_id1 <= rd_id0;
            rvalid <= rd_v1;
            if (rd_v1) begin
                rid   <= rd_id1;
                rdata <= ram_dout;
            end
        end
    end

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: behavioural RAM model, directed drivers, and a
// scoreboard queue checked by an independent read-return monitor.
module tb_ram_arbiter;

    localparam int AW   = 8;
    localparam int DW   = 8;
    localparam int NREQ = 4;
    localparam int IDW  = 2;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [NREQ-1:0]   wreq, rreq, wack, rack;
    logic [NREQ*AW-1:0] waddr, raddr;
    logic [NREQ*DW-1:0] wdata;
    logic              rvalid, init_done, ram_we;
    logic [IDW-1:0]    rid;
    logic [DW-1:0]     rdata, ram_din, ram_dout;
    logic [AW-1:0]     ram_waddr, ram_raddr;

    int n_tests = 0;
    int n_fail  = 0;
    logic [IDW+DW-1:0] exp_q[$];
    logic [DW-1:0]     tb_mem [0:255];

    ram_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NREQ(NREQ), .ID_WIDTH(IDW)) dut (
        .clk(clk), .rst_n(rst_n),
        .wreq(wreq), .waddr(waddr), .wdata(wdata), .wack(wack),
        .rreq(rreq), .raddr(raddr), .rack(rack),
        .rvalid(rvalid), .rid(rid), .rdata(rdata), .init_done(init_done),
        .ram_we(ram_we), .ram_waddr(ram_waddr), .ram_din(ram_din),
        .ram_raddr(ram_raddr), .ram_dout(ram_dout)
    );

    always #5 clk = ~clk;

    // RAM model: registered read address, combinational data out, garbage at power-up.
    logic [DW-1:0] mem [0:255];
    logic [AW-1:0] raddr_q = '0;
    initial for (int i = 0; i < 256; i++) mem[i] = 8'hEE;
    always @(posedge clk) begin
        if (ram_we) mem[ram_waddr] <= ram_din;
        raddr_q <= ram_raddr;
    end
    assign ram_dout = mem[raddr_q];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_reset_values();
        check("rst_wack", wack, 0);
        check("rst_rack", rack, 0);
        check("rst_rvalid", rvalid, 0);
        check("rst_rid", rid, 0);
        check("rst_rdata", rdata, 0);
        check("rst_init_done", init_done, 0);
        check("rst_ram_we", ram_we, 0);
        check("rst_ram_waddr", ram_waddr, 0);
        check("rst_ram_din", ram_din, 0);
        check("rst_ram_raddr", ram_raddr, 0);
    endtask

    // Monitor: pops the expected queue on every rvalid and checks rack-to-rvalid latency.
    logic [NREQ-1:0] rack_d1 = '0, rack_d2 = '0, rid_oh;
    logic [IDW+DW-1:0] exp_e;
    always @(negedge clk) begin
        if (!rst_n) begin
            rack_d1 = '0;
            rack_d2 = '0;
        end else begin
            if (rvalid || (rack_d2 != '0)) begin
                check("rvalid_latency", rvalid, |rack_d2);
                if (rvalid) begin
                    rid_oh = 4'b0001 << rid;
                    check("rid_vs_rack", rid_oh, rack_d2);
                    if (exp_q.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL unexpected_rvalid: got rid=%0d rdata=%0h with empty queue", rid, rdata);
                    end else begin
                        exp_e = exp_q.pop_front();
                        check("rid", rid, exp_e[DW +: IDW]);
                        check("rdata", rdata, exp_e[DW-1:0]);
                    end
                end
            end
            rack_d2 = rack_d1;
            rack_d1 = rack;
        end
    end

    task automatic do_write(input int id, input logic [AW-1:0] a, input logic [DW-1:0] d);
        bit got = 0;
        wreq[id] = 1'b1;
        waddr[id*AW +: AW] = a;
        wdata[id*DW +: DW] = d;
        tb_mem[a] = d;
        for (int t = 0; t < 20 && !got; t++) begin
            @(negedge clk);
            if (wack[id]) got = 1;
        end
        wreq[id] = 1'b0;
        if (!got) begin
            n_tests++;
            n_fail++;
            $display("FAIL wack_timeout: got no wack[%0d] expected one within 20 cycles", id);
        end
    endtask

    task automatic do_read(input int id, input logic [AW-1:0] a, input bit expect_data);
        bit got = 0;
        rreq[id] = 1'b1;
        raddr[id*AW +: AW] = a;
        if (expect_data) exp_q.push_back({IDW'(id), tb_mem[a]});
        for (int t = 0; t < 20 && !got; t++) begin
            @(negedge clk);
            if (rack[id]) got = 1;
        end
        rreq[id] = 1'b0;
        if (!got) begin
            n_tests++;
            n_fail++;
            $display("FAIL rack_timeout: got no rack[%0d] expected one within 20 cycles", id);
        end
    endtask

    logic [NREQ-1:0] rr_exp [0:8];
    int we_cnt, addr_err, done_cyc, first_ack, rack_cnt;

    initial begin
        wreq = '0; rreq = '0; waddr = '0; raddr = '0; wdata = '0;
        for (int i = 0; i < 256; i++) tb_mem[i] = '0;
        repeat (3) @(negedge clk);
        check_reset_values();

        // Zero-fill, with a read held pending through INIT.
        rreq[3] = 1'b1;
        raddr[3*AW +: AW] = 8'h40;
        exp_q.push_back({2'd3, 8'h00});
        rst_n = 1'b1;
        we_cnt = 0; addr_err = 0; done_cyc = 0; first_ack = 0;
        for (int n = 1; n <= 262; n++) begin
            @(negedge clk);
            if (ram_we) begin
                we_cnt++;
                if (n > 256 || ram_waddr != AW'(n-1) || ram_din != '0) addr_err++;
            end
            if (init_done && done_cyc == 0) done_cyc = n;
            if ((wack != '0 || rack != '0) && first_ack == 0) first_ack = n;
            if (rack[3]) rreq[3] = 1'b0;
        end
        check("init_we_cycles", we_cnt, 256);
        check("init_fill_seq", addr_err, 0);
        check("init_done_cycle", done_cyc, 257);
        check("first_ack_cycle", first_ack, 258);

        for (int a = 0; a < 256; a++) do_read(0, AW'(a), 1'b1);
        repeat (4) @(negedge clk);

        // Round-robin: all four, then 0 and 2 only.
        rr_exp[0] = 4'b0001; rr_exp[1] = 4'b0010; rr_exp[2] = 4'b0100; rr_exp[3] = 4'b1000;
        rr_exp[4] = 4'b0001; rr_exp[5] = 4'b0100; rr_exp[6] = 4'b0001; rr_exp[7] = 4'b0100;
        rr_exp[8] = 4'b0001;
        for (int i = 0; i < NREQ; i++) begin
            waddr[i*AW +: AW] = AW'(8'h80 + i);
            wdata[i*DW +: DW] = DW'(8'h10 + i);
            tb_mem[8'h80 + i] = DW'(8'h10 + i);
        end
        wreq = 4'b1111;
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            check($sformatf("rr_wack_%0d", i), wack, rr_exp[i]);
            if (i == 4) wreq = 4'b0101;
        end
        wreq = '0;
        repeat (2) @(negedge clk);
        do_read(3, 8'h82, 1'b1);
        do_read(2, 8'h81, 1'b1);

        // Write then read from another requester.
        do_write(0, 8'h12, 8'hA5);
        repeat (3) @(negedge clk);
        do_read(1, 8'h12, 1'b1);
        repeat (3) @(negedge clk);

        // Same-cycle write and read of one address returns the new data.
        wreq[0] = 1'b1; waddr[0 +: AW] = 8'h05; wdata[0 +: DW] = 8'h3C;
        rreq[1] = 1'b1; raddr[AW +: AW] = 8'h05;
        tb_mem[5] = 8'h3C;
        exp_q.push_back({2'd1, 8'h3C});
        @(negedge clk);
        check("collide_wack", wack, 4'b0001);
        check("collide_rack", rack, 4'b0010);
        wreq = '0; rreq = '0;
        repeat (4) @(negedge clk);

        // Lone requester held for 10 cycles.
        rreq[2] = 1'b1; raddr[2*AW +: AW] = 8'h12;
        for (int i = 0; i < 5; i++) exp_q.push_back({2'd2, 8'hA5});
        rack_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (rack[2]) rack_cnt++;
        end
        rreq[2] = 1'b0;
        check("held_rack_count", rack_cnt, 5);
        repeat (5) @(negedge clk);
        check("queue_drained", exp_q.size(), 0);

        // Reset in the cycle after a read grant drops the read.
        do_read(3, 8'h12, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_reset_values();
        repeat (2) @(negedge clk);
        check("rst_no_rvalid", rvalid, 0);
        check_reset_values();
        for (int i = 0; i < 256; i++) tb_mem[i] = '0;
        rst_n = 1'b1;
        @(negedge clk);
        check("reinit_we", ram_we, 1);
        check("reinit_addr0", ram_waddr, 0);
        check("reinit_done_low", init_done, 0);
        @(negedge clk);
        check("reinit_addr1", ram_waddr, 1);
        repeat (258) @(negedge clk);
        check("reinit_done", init_done, 1);
        do_write(2, 8'h33, 8'h5A);
        do_read(0, 8'h33, 1'b1);
        do_read(1, 8'h12, 1'b1);
        repeat (5) @(negedge clk);
        check("final_queue_drained", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test expected completion within 200000 ns");
        $fatal(1, "watchdog");
    end

endmodule
